// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and imem request/ready handshake with freeze, redirect and stale-response drop.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        bubble
);
  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;
  state_t      state;
  logic [31:0] pc, hold_inst, hold_pc, drop_addr, target, rpc, pc_inc;
  assign rpc    = redirect_pc & ~32'h3;
  assign pc_inc = pc + 32'd4;
  always_comb begin
    imem_req   = !rst && state != HOLD;
    imem_addr  = rst ? 32'h0 : state == DROP ? drop_addr : pc;
    inst_valid = !rst && !redirect && (state == HOLD || (state == FETCH && imem_ready));
    inst_out   = !inst_valid ? 32'h0 : state == HOLD ? hold_inst : imem_rdata;
    pc_out     = !inst_valid ? 32'h0 : state == HOLD ? hold_pc : pc_inc;
    bubble     = !inst_valid;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      hold_inst <= 32'h0;
      hold_pc   <= 32'h0;
      drop_addr <= 32'h0;
      target    <= 32'h0;
    end else if (redirect) begin
      // A redirect with a request still pending must let that request finish first.
      if (state == FETCH && !imem_ready) begin
        drop_addr <= pc;
        target    <= rpc;
        state     <= DROP;
      end else if (state == DROP && !imem_ready) begin
        target <= rpc;
      end else begin
        target <= state == DROP ? rpc : target;
        pc     <= rpc;
        state  <= FETCH;
      end
    end else if (state == HOLD) begin
      if (!freeze) begin
        pc    <= pc_inc;
        state <= FETCH;
      end
    end else if (state == DROP) begin
      if (imem_ready) begin
        pc    <= target;
        state <= FETCH;
      end
    end else if (imem_ready) begin
      if (freeze) begin
        hold_inst <= imem_rdata;
        hold_pc   <= pc_inc;
        state     <= HOLD;
      end else begin
        pc <= pc_inc;
      end
    end
  end
endmodule
